writeback_stage: RTL

Parametrised, registered write-back stage for the multicycle MIPS datapath. It replaces the single 2:1 MemtoReg select with a small state machine that captures the result sources, performs load sign/zero extension and byte-lane alignment, checks alignment, and issues exactly one register-file write per request. It sits between the memory-data/ALU-out registers and the register file. It also keeps a last-write record that the control unit uses for bypass.

---
 rtl/writeback_stage_pkg.sv | 34 +++
 rtl/writeback_stage_load_align.sv | 54 +++++
 rtl/writeback_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the write-back stage: result sources, load types,
// FSM states and the byte-lane helper.
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_LINK = 2'd2,
    SRC_LUI  = 2'd3
  } src_sel_e;

  // Codes 5..7 are reserved and always flag a misaligned load.
  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_COMMIT = 2'd2
  } wb_state_e;

  localparam int DATA_W_DEFAULT = 32;
  localparam int LANES          = DATA_W_DEFAULT / 8;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load lane select with sign/zero extension and alignment check.
// Lanes are little-endian: byte_off 0 is read_data[7:0].
module load_align
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [2:0]        load_type,
  input  logic [OFF_W-1:0]  byte_off,
  output logic [DATA_W-1:0] ext_data,
  output logic              misaligned
);

  logic [DATA_W-1:0] lane_shift;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  always_comb begin
    lane_shift = read_data >> {byte_off, 3'b000};
    byte_v     = lane_shift[7:0];
    half_v     = lane_shift[15:0];
    ext_data   = read_data;
    misaligned = 1'b1;
    case (load_type)
      LD_LW: begin
        ext_data   = read_data;
        misaligned = (byte_off != '0);
      end
      LD_LH: begin
        ext_data   = {{(DATA_W-16){half_v[15]}}, half_v};
        misaligned = byte_off[0];
      end
      LD_LHU: begin
        ext_data   = {{(DATA_W-16){1'b0}}, half_v};
        misaligned = byte_off[0];
      end
      LD_LB: begin
        ext_data   = {{(DATA_W-8){byte_v[7]}}, byte_v};
        misaligned = 1'b0;
      end
      LD_LBU: begin
        ext_data   = {{(DATA_W-8){1'b0}}, byte_v};
        misaligned = 1'b0;
      end
      default: begin
        ext_data   = read_data;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Three-state write-back stage: capture request, align/extend the result,
// then issue a single register-file write and refresh the bypass record.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [1:0]                    src_sel,
  input  logic [2:0]                    load_type,
  input  logic [$clog2(DATA_W/8)-1:0]   byte_off,
  input  logic [REG_AW-1:0]             wr_addr_in,
  input  logic [DATA_W-1:0]             read_data,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic [DATA_W-1:0]             pc_plus4,
  input  logic [15:0]                   imm16,
  output logic                          reg_write,
  output logic [REG_AW-1:0]             write_addr,
  output logic [DATA_W-1:0]             writeData,
  output logic                          done,
  output logic                          misalign,
  output logic                          last_valid,
  output logic [REG_AW-1:0]             last_addr,
  output logic [DATA_W-1:0]             last_data
);

  localparam int OFF_W = $clog2(lanes_of(DATA_W));

  wb_state_e           state_q, state_d;
  logic [1:0]          src_q, src_d;
  logic [2:0]          lt_q, lt_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [REG_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rd_q, rd_d, alu_q, alu_d, pc_q, pc_d;
  logic [15:0]         imm_q, imm_d;

  logic                reg_write_q, reg_write_d, done_q, done_d, misalign_q, misalign_d;
  logic [REG_AW-1:0]   write_addr_q, write_addr_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                last_valid_q, last_valid_d;
  logic [REG_AW-1:0]   last_addr_q, last_addr_d;
  logic [DATA_W-1:0]   last_data_q, last_data_d;

  logic [DATA_W-1:0]   align_data, result, lui_v;
  logic                align_mis, mis;

  load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_load_align (
    .read_data  (rd_q),
    .load_type  (lt_q),
    .byte_off   (off_q),
    .ext_data   (align_data),
    .misaligned (align_mis)
  );

  always_comb begin
    lui_v        = '0;
    lui_v[31:16] = imm_q;
    case (src_q)
      SRC_ALU:  result = alu_q;
      SRC_MEM:  result = align_data;
      SRC_LINK: result = pc_q;
      default:  result = lui_v;
    endcase
    mis = (src_q == SRC_MEM) && align_mis;
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    lt_d         = lt_q;
    off_d        = off_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    reg_write_d  = 1'b0;
    done_d       = 1'b0;
    misalign_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    last_data_d  = last_data_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_valid) begin
          src_d   = src_sel;
          lt_d    = load_type;
          off_d   = byte_off;
          addr_d  = wr_addr_in;
          rd_d    = read_data;
          alu_d   = alu_result;
          pc_d    = pc_plus4;
          imm_d   = imm16;
          state_d = ST_ALIGN;
        end
      end
      // Result and write strobes are registered here so they are all
      // valid for exactly the COMMIT cycle.
      ST_ALIGN: begin
        write_addr_d = addr_q;
        write_data_d = result;
        done_d       = 1'b1;
        misalign_d   = mis;
        reg_write_d  = !mis && (addr_q != '0);
        if (reg_write_d) begin
          last_valid_d = 1'b1;
          last_addr_d  = addr_q;
          last_data_d  = result;
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      reg_write_q  <= 1'b0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
      last_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= reg_write_d;
      done_q       <= done_d;
      misalign_q   <= misalign_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
    end
  end

  // Captured request operands carry no reset; they are only read after capture.
  always_ff @(posedge clk) begin
    src_q  <= src_d;
    lt_q   <= lt_d;
    off_q  <= off_d;
    addr_q <= addr_d;
    rd_q   <= rd_d;
    alu_q  <= alu_d;
    pc_q   <= pc_d;
    imm_q  <= imm_d;
  end

  assign wb_ready   = (state_q == ST_IDLE);
  assign reg_write  = reg_write_q;
  assign done       = done_q;
  assign misalign   = misalign_q;
  assign write_addr = write_addr_q;
  assign writeData  = write_data_q;
  assign last_valid = last_valid_q;
  assign last_addr  = last_addr_q;
  assign last_data  = last_data_q;

endmodule
